// File: rtl/regfile_pkg.sv
// Shared encodings for the banked register-file writeback scheduler:
// ARM mode values, exception type codes, vector offsets and small decode helpers.
package regfile_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam logic [2:0] EXC_UND  = 3'd1;
  localparam logic [2:0] EXC_SVC  = 3'd2;
  localparam logic [2:0] EXC_PABT = 3'd3;
  localparam logic [2:0] EXC_DABT = 3'd4;
  localparam logic [2:0] EXC_IRQ  = 3'd6;
  localparam logic [2:0] EXC_FIQ  = 3'd7;

  localparam logic [31:0] VEC_UND  = 32'h04;
  localparam logic [31:0] VEC_SVC  = 32'h08;
  localparam logic [31:0] VEC_PABT = 32'h0C;
  localparam logic [31:0] VEC_DABT = 32'h10;
  localparam logic [31:0] VEC_IRQ  = 32'h18;
  localparam logic [31:0] VEC_FIQ  = 32'h1C;

  localparam logic [3:0] PC_ADDR = 4'd15;
  localparam logic [3:0] LR_ADDR = 4'd14;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_EXC_MODE = 2'd1,
    S_EXC_LR   = 2'd2,
    S_EXC_PC   = 2'd3
  } state_t;

  function automatic logic exc_legal(input logic [2:0] t);
    exc_legal = (t != 3'd0) && (t != 3'd5);
  endfunction

  function automatic logic [4:0] mode_of(input logic [2:0] t);
    case (t)
      EXC_UND:  mode_of = MODE_UND;
      EXC_SVC:  mode_of = MODE_SVC;
      EXC_PABT: mode_of = MODE_ABT;
      EXC_DABT: mode_of = MODE_ABT;
      EXC_IRQ:  mode_of = MODE_IRQ;
      EXC_FIQ:  mode_of = MODE_FIQ;
      default:  mode_of = MODE_SVC;
    endcase
  endfunction

  function automatic logic [31:0] vec_of(input logic [2:0] t);
    case (t)
      EXC_UND:  vec_of = VEC_UND;
      EXC_SVC:  vec_of = VEC_SVC;
      EXC_PABT: vec_of = VEC_PABT;
      EXC_DABT: vec_of = VEC_DABT;
      EXC_IRQ:  vec_of = VEC_IRQ;
      EXC_FIQ:  vec_of = VEC_FIQ;
      default:  vec_of = 32'h0;
    endcase
  endfunction

  // Mode must have M[4] set and a defined low nibble (usr/fiq/irq/svc/mon/abt/hyp/und/sys).
  function automatic logic mode_legal(input logic [4:0] m);
    case (m[3:0])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'hA, 4'hB, 4'hF: mode_legal = m[4];
      default: mode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-way round-robin arbiter: index 0 is ALU, index 1 is LSU.
// The pointer moves to the other requester after every grant.
module wb_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);

  always_comb begin
    grant = 2'b00;
    if (advance) begin
      if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                ptr <= 1'b0;
    else if (grant[0])       ptr <= 1'b1;
    else if (grant[1])       ptr <= 1'b0;
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Owns the register-file write port, PC write and mode field M: arbitrates ALU/LSU
// writeback, sequences exception entry and applies software mode writes.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter logic [31:0] VEC_BASE = 32'h0000_0000,
  parameter logic [4:0]  RST_MODE = 5'b10011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [3:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic [3:0]  lsu_addr,
  input  logic [31:0] lsu_data,
  input  logic        exc_req,
  input  logic [2:0]  exc_type,
  input  logic [31:0] exc_ret,
  output logic        exc_ack,
  output logic        exc_done,
  input  logic        mode_wr_valid,
  input  logic [4:0]  mode_wr_data,
  output logic        err,
  output logic [3:0]  w_addr,
  output logic [31:0] w_data,
  output logic        write_reg,
  output logic        write_pc,
  output logic [31:0] pc_data,
  output logic [4:0]  M,
  output logic [4:0]  spsr_m,
  output state_t      state_dbg
);

  // Handshake: a writeback transfers on a cycle where valid && ready; ready is
  // combinational and only asserted in IDLE with no exception or mode request pending.

  state_t      state, state_n;
  logic [2:0]  exc_type_q, exc_type_d;
  logic [31:0] exc_ret_q, exc_ret_d;
  logic [4:0]  m_d, spsr_d;
  logic [3:0]  w_addr_d;
  logic [31:0] w_data_d, pc_data_d;
  logic        write_reg_d, write_pc_d, exc_ack_d, exc_done_d, err_d;
  logic [1:0]  grant;
  logic        rr_ptr;
  logic        wb_open;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;

  assign wb_open   = (state == S_IDLE) && !exc_req && !mode_wr_valid;
  assign alu_ready = grant[0];
  assign lsu_ready = grant[1];
  assign state_dbg = state;

  wb_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   ({lsu_valid, alu_valid}),
    .advance (wb_open),
    .grant   (grant),
    .ptr     (rr_ptr)
  );

  assign wb_addr = grant[1] ? lsu_addr : alu_addr;
  assign wb_data = grant[1] ? lsu_data : alu_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      exc_type_q <= 3'd0;
      exc_ret_q  <= 32'h0;
      M          <= RST_MODE;
      spsr_m     <= RST_MODE;
      w_addr     <= 4'd0;
      w_data     <= 32'h0;
      pc_data    <= 32'h0;
      write_reg  <= 1'b0;
      write_pc   <= 1'b0;
      exc_ack    <= 1'b0;
      exc_done   <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      exc_type_q <= exc_type_d;
      exc_ret_q  <= exc_ret_d;
      M          <= m_d;
      spsr_m     <= spsr_d;
      w_addr     <= w_addr_d;
      w_data     <= w_data_d;
      pc_data    <= pc_data_d;
      write_reg  <= write_reg_d;
      write_pc   <= write_pc_d;
      exc_ack    <= exc_ack_d;
      exc_done   <= exc_done_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (exc_req && exc_legal(exc_type)) state_n = S_EXC_MODE;
      S_EXC_MODE: state_n = S_EXC_LR;
      S_EXC_LR:   state_n = S_EXC_PC;
      S_EXC_PC:   state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_comb begin
    exc_type_d  = exc_type_q;
    exc_ret_d   = exc_ret_q;
    m_d         = M;
    spsr_d      = spsr_m;
    w_addr_d    = w_addr;
    w_data_d    = w_data;
    pc_data_d   = pc_data;
    write_reg_d = 1'b0;
    write_pc_d  = 1'b0;
    exc_ack_d   = 1'b0;
    exc_done_d  = 1'b0;
    err_d       = 1'b0;
    case (state)
      S_IDLE: begin
        if (exc_req) begin
          exc_ack_d  = 1'b1;
          err_d      = !exc_legal(exc_type);
          exc_type_d = exc_type;
          exc_ret_d  = exc_ret;
        end else if (mode_wr_valid) begin
          if (mode_legal(mode_wr_data)) m_d = mode_wr_data;
          else                          err_d = 1'b1;
        end else if (grant != 2'b00) begin
          // PC-targeted writebacks go to the PC port, never the register strobe.
          if (wb_addr == PC_ADDR) begin
            write_pc_d = 1'b1;
            pc_data_d  = wb_data;
          end else begin
            write_reg_d = 1'b1;
            w_addr_d    = wb_addr;
            w_data_d    = wb_data;
          end
        end
      end
      S_EXC_MODE: begin
        spsr_d = M;
        m_d    = mode_of(exc_type_q);
      end
      S_EXC_LR: begin
        write_reg_d = 1'b1;
        w_addr_d    = LR_ADDR;
        w_data_d    = exc_ret_q;
      end
      S_EXC_PC: begin
        write_pc_d = 1'b1;
        pc_data_d  = VEC_BASE + vec_of(exc_type_q);
        exc_done_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
